// File: rtl/cardinal_router_local_port.sv
// Router-side endpoint of the NIC link: owns link polarity, two 1-deep VC buffers
// per direction, and a sticky VC protocol-error flag.
module cardinal_router_local_port #(
   parameter int DATA_W = 64,
   parameter int VC_LSB = 0
) (
   input  logic              clk,
   input  logic              reset,
   output logic              net_polarity,
   input  logic              net_so,
   output logic              net_ro,
   input  logic [DATA_W-1:0] net_do,
   output logic              net_si,
   input  logic              net_ri,
   output logic [DATA_W-1:0] net_di,
   output logic              inj_valid,
   input  logic              inj_ready,
   output logic [DATA_W-1:0] inj_data,
   input  logic              ej_valid,
   output logic              ej_ready,
   input  logic [DATA_W-1:0] ej_data,
   output logic              vc_err
);

   logic              polarity;
   logic [1:0]        inj_full;
   logic [1:0]        ej_full;
   logic [DATA_W-1:0] inj_buf [2];
   logic [DATA_W-1:0] ej_buf  [2];

   logic link_vc, fab_vc;
   logic inj_hit, inj_bad, inj_take;
   logic ej_hit, ej_bad;

   // Link side always works on VC == polarity, fabric side on the opposite VC,
   // so capture and drain never target the same buffer in one cycle.
   always_comb begin
      link_vc      = polarity;
      fab_vc       = ~polarity;
      net_polarity = polarity;

      net_ro   = ~inj_full[link_vc];
      inj_hit  = net_so & net_ro & (net_do[VC_LSB] == link_vc);
      inj_bad  = net_so & net_ro & (net_do[VC_LSB] != link_vc);

      inj_valid = inj_full[fab_vc];
      inj_data  = inj_valid ? inj_buf[fab_vc] : '0;
      inj_take  = inj_valid & inj_ready;

      ej_ready = ~ej_full[fab_vc];
      ej_hit   = ej_valid & ej_ready & (ej_data[VC_LSB] == fab_vc);
      ej_bad   = ej_valid & ej_ready & (ej_data[VC_LSB] != fab_vc);

      net_si = ej_full[link_vc] & net_ri;
      net_di = net_si ? ej_buf[link_vc] : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         polarity <= 1'b0;
         inj_full <= '0;
         ej_full  <= '0;
         vc_err   <= 1'b0;
         for (int unsigned i = 0; i < 2; i++) begin
            inj_buf[i] <= '0;
            ej_buf[i]  <= '0;
         end
      end else begin
         polarity <= ~polarity;
         if (inj_hit) begin
            inj_buf[link_vc]  <= net_do;
            inj_full[link_vc] <= 1'b1;
         end
         if (inj_take)
            inj_full[fab_vc] <= 1'b0;
         if (ej_hit) begin
            ej_buf[fab_vc]  <= ej_data;
            ej_full[fab_vc] <= 1'b1;
         end
         if (net_si)
            ej_full[link_vc] <= 1'b0;
         if (inj_bad | ej_bad)
            vc_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cardinal_router_local_port.sv
// Self-checking bench: directed test-plan scenarios plus randomized traffic,
// compared every cycle against a per-VC slot model driven by cycle phase.
module tb_cardinal_router_local_port;

   logic        clk = 1'b0;
   logic        reset;
   logic        net_polarity;
   logic        net_so;
   logic        net_ro;
   logic [63:0] net_do;
   logic        net_si;
   logic        net_ri;
   logic [63:0] net_di;
   logic        inj_valid;
   logic        inj_ready;
   logic [63:0] inj_data;
   logic        ej_valid;
   logic        ej_ready;
   logic [63:0] ej_data;
   logic        vc_err;

   int tests_run = 0;
   int tests_failed = 0;

   // Reference model: one optional flit per (direction, VC), plus cycle count since reset.
   bit          m_inj_has [2];
   logic [63:0] m_inj_dat [2];
   bit          m_ej_has  [2];
   logic [63:0] m_ej_dat  [2];
   bit          m_err;
   int unsigned cyc;

   cardinal_router_local_port #(.DATA_W(64), .VC_LSB(0)) dut (
      .clk(clk), .reset(reset), .net_polarity(net_polarity),
      .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
      .net_si(net_si), .net_ri(net_ri), .net_di(net_di),
      .inj_valid(inj_valid), .inj_ready(inj_ready), .inj_data(inj_data),
      .ej_valid(ej_valid), .ej_ready(ej_ready), .ej_data(ej_data),
      .vc_err(vc_err)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
      end
   endtask

   task automatic run_cycle(input bit rst, input bit so, input logic [63:0] d_o, input bit ri,
                            input bit irdy, input bit ejv, input logic [63:0] ejd);
      bit ph, e_ro, e_iv, e_er, e_si;
      logic [63:0] e_id, e_di;
      @(negedge clk);
      reset = rst; net_so = so; net_do = d_o; net_ri = ri;
      inj_ready = irdy; ej_valid = ejv; ej_data = ejd;
      #1;
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            m_inj_has[i] = 0; m_ej_has[i] = 0;
         end
         m_err = 0;
         cyc = 0;
      end else begin
         ph   = cyc[0];
         e_ro = !m_inj_has[ph];
         e_iv = m_inj_has[!ph];
         e_id = e_iv ? m_inj_dat[!ph] : 64'h0;
         e_er = !m_ej_has[!ph];
         e_si = m_ej_has[ph] && ri;
         e_di = e_si ? m_ej_dat[ph] : 64'h0;

         check_val("polarity",  {63'h0, net_polarity}, {63'h0, ph});
         check_val("net_ro",    {63'h0, net_ro},       {63'h0, e_ro});
         check_val("inj_valid", {63'h0, inj_valid},    {63'h0, e_iv});
         check_val("inj_data",  inj_data,              e_id);
         check_val("ej_ready",  {63'h0, ej_ready},     {63'h0, e_er});
         check_val("net_si",    {63'h0, net_si},       {63'h0, e_si});
         check_val("net_di",    net_di,                e_di);
         check_val("vc_err",    {63'h0, vc_err},       {63'h0, m_err});

         if (so && e_ro) begin
            if (d_o[0] == ph) begin m_inj_has[ph] = 1; m_inj_dat[ph] = d_o; end
            else m_err = 1;
         end
         if (e_iv && irdy) m_inj_has[!ph] = 0;
         if (ejv && e_er) begin
            if (ejd[0] == !ph) begin m_ej_has[!ph] = 1; m_ej_dat[!ph] = ejd; end
            else m_err = 1;
         end
         if (e_si) m_ej_has[ph] = 0;
         cyc++;
      end
   endtask

   task automatic idle(input bit ri, input bit irdy);
      run_cycle(0, 0, 64'h0, ri, irdy, 0, 64'h0);
   endtask

   task automatic align(input bit ph, input bit ri, input bit irdy);
      if (cyc[0] != ph) idle(ri, irdy);
   endtask

   task automatic random_traffic(input int n, input int bad_pct);
      bit ph;
      logic [63:0] d, e;
      for (int k = 0; k < n; k++) begin
         ph = cyc[0];
         d = {$urandom, $urandom};
         e = {$urandom, $urandom};
         d[0] = ($urandom_range(99) < bad_pct) ? !ph : ph;
         e[0] = ($urandom_range(99) < bad_pct) ? ph : !ph;
         run_cycle(0, $urandom_range(1), d, $urandom_range(3) != 0,
                   $urandom_range(3) != 0, $urandom_range(1), e);
      end
   endtask

   initial begin
      reset = 1; net_so = 0; net_do = '0; net_ri = 0;
      inj_ready = 0; ej_valid = 0; ej_data = '0;
      cyc = 0; m_err = 0;
      run_cycle(1, 0, 64'h0, 0, 0, 0, 64'h0);
      run_cycle(1, 0, 64'h0, 0, 0, 0, 64'h0);

      // reset values and polarity sequence 0,1,0,1
      repeat (4) idle(1, 1);

      // basic injection
      align(0, 1, 1);
      run_cycle(0, 1, 64'hDEAD_BEEF_0000_00A0, 1, 1, 0, 64'h0);
      repeat (3) idle(1, 1);

      // injection backpressure, then drain
      align(0, 1, 0);
      run_cycle(0, 1, 64'h10, 1, 0, 0, 64'h0);
      run_cycle(0, 1, 64'h11, 1, 0, 0, 64'h0);
      repeat (4) idle(1, 0);
      repeat (4) idle(1, 1);

      // basic ejection, delivered immediately
      align(0, 1, 1);
      run_cycle(0, 0, 64'h0, 1, 1, 1, 64'hCAFE_0000_0000_00B1);
      repeat (2) idle(1, 1);
      // ejection held by net_ri=0, re-offered two cycles later
      align(0, 1, 1);
      run_cycle(0, 0, 64'h0, 0, 1, 1, 64'hCAFE_0000_0000_00B1);
      repeat (2) idle(0, 1);
      repeat (2) idle(1, 1);

      // VC error: odd flit in a polarity-0 cycle
      align(0, 1, 1);
      run_cycle(0, 1, 64'h1234_0000_0000_0001, 1, 1, 0, 64'h0);
      repeat (4) idle(1, 1);
      run_cycle(1, 0, 64'h0, 0, 0, 0, 64'h0);

      random_traffic(400, 0);

      // fill all four buffers, then reset mid-transfer
      align(0, 0, 0);
      run_cycle(0, 1, 64'hAAAA_0000_0000_0000, 0, 0, 1, 64'hBBBB_0000_0000_0001);
      run_cycle(0, 1, 64'hAAAA_0000_0000_0001, 0, 0, 1, 64'hBBBB_0000_0000_0000);
      idle(0, 0);
      run_cycle(1, 0, 64'h0, 1, 1, 0, 64'h0);
      repeat (4) idle(1, 1);

      random_traffic(300, 10);
      run_cycle(1, 0, 64'h0, 0, 0, 0, 64'h0);
      random_traffic(200, 3);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/cardinal_router_local_port.md
Name: cardinal_router_local_port

Overview:
- Router-side endpoint of the NIC link, facing cardinal_nic's net_* ports. Owns the link polarity.
- Buffers injected flits from the NIC into two 1-deep virtual-channel (VC) buffers, then hands them to the router switch fabric.
- Buffers fabric flits bound for the local PE into two 1-deep VC buffers, then delivers them to the NIC.
- External link traffic uses VC == polarity; internal fabric traffic uses VC == ~polarity. The polarity toggles every cycle.

Parameters:
- DATA_W, 64, flit width.
- VC_LSB, 0, bit position of the VC bit inside a flit.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- net_polarity  out  1  current external VC phase, driven to the NIC
- net_so  in  1  NIC sending a flit to the router
- net_ro  out  1  router ready to accept from the NIC
- net_do  in  DATA_W  flit from the NIC
- net_si  out  1  router sending a flit to the NIC
- net_ri  in  1  NIC ready to receive
- net_di  out  DATA_W  flit to the NIC
- inj_valid  out  1  injected flit available to the fabric
- inj_ready  in  1  fabric accepts the injected flit
- inj_data  out  DATA_W  injected flit
- ej_valid  in  1  fabric offering a flit for ejection
- ej_ready  out  1  port accepts the ejection flit
- ej_data  in  DATA_W  ejection flit
- vc_err  out  1  sticky protocol-error flag

Behaviour:
- Clock and reset: clk and reset are already decided; reset is synchronous and active-high.
- Reset values:
  - polarity=0; all four VC buffers empty, data cleared.
  - net_ro=1, net_si=0, net_di=0.
  - inj_valid=0, inj_data=0, ej_ready=1, vc_err=0.
- Polarity:
  - Register; toggles on every clk edge while reset is low.
  - net_polarity is the register output.
  - The first post-reset cycle has polarity 0.
- Injection capture (NIC to port):
  - net_ro = ~inj_full[polarity], decoded combinationally from registers.
  - Capture condition: net_so & net_ro & (net_do[VC_LSB]==polarity). On the edge, inj_buf[polarity] <= net_do and inj_full[polarity] <= 1.
  - VC mismatch (net_so & net_ro & net_do[VC_LSB]!=polarity): flit dropped, vc_err <= 1.
  - net_so while net_ro=0: ignored, no state change, no error.
- Injection forward (port to fabric):
  - inj_valid = inj_full[~polarity]; inj_data = inj_buf[~polarity] when valid, else 0.
  - inj_valid & inj_ready clears inj_full[~polarity] on the edge.
  - Capture and forward always address different buffers in a cycle, so no same-buffer conflict exists.
- Ejection accept (fabric to port):
  - ej_ready = ~ej_full[~polarity].
  - Accept condition: ej_valid & ej_ready & (ej_data[VC_LSB]==~polarity). On the edge, ej_buf[~polarity] <= ej_data and ej_full[~polarity] <= 1.
  - VC mismatch: flit dropped, vc_err <= 1.
- Ejection deliver (port to NIC):
  - net_si = ej_full[polarity] & net_ri; net_di = ej_buf[polarity] when net_si=1, else 0.
  - net_si clears ej_full[polarity] on the same edge.
- Latency:
  - A flit captured in phase p is presented in the next cycle, with phase ~p.
  - NIC to fabric minimum latency: 1 cycle. Fabric to NIC minimum latency: 1 cycle.
- Backpressure: a full buffer holds its flit indefinitely. The flit is re-offered every other cycle, whenever its VC phase recurs.
- Simultaneous events: injection capture, injection forward, ejection accept and ejection deliver may all occur in one cycle; they are fully independent.
- vc_err is sticky; only reset clears it.
- Reset asserted mid-transfer: every buffered flit is discarded, and polarity returns to 0 on the next cycle.
- All outputs are functions of registers plus net_ri only; there is no combinational path from net_so, net_do, ej_valid, ej_data, or inj_ready to any output.

Test Plan:
- Reset check: release reset -> net_polarity sequence 0,1,0,1; net_ro=1, ej_ready=1, net_si=0, inj_valid=0, vc_err=0.
- Basic injection: net_so=1, net_do=64'h...A0 (VC 0) in a polarity-0 cycle -> next cycle inj_valid=1, inj_data=64'h...A0; inj_ready=1 clears it; net_ro returns to 1 in the next polarity-0 cycle.
- Injection backpressure: hold inj_ready=0 and inject VC-0 flit 64'h10 -> net_ro=0 in every polarity-0 cycle; a VC-1 flit 64'h11 is still accepted in a polarity-1 cycle; both drain in order of phase once inj_ready=1.
- Basic ejection: ej_valid=1, ej_data=64'h...B1 (VC 1) in a polarity-0 cycle -> next cycle (polarity 1) with net_ri=1: net_si=1, net_di=64'h...B1 for exactly one cycle; with net_ri=0 the flit is held and re-offered at polarity 1 two cycles later.
- VC error: net_so=1 with net_do[0]=1 in a polarity-0 cycle -> flit dropped, inj_valid stays 0, vc_err=1 and remains 1 until reset.
- Concurrency plus reset: all four paths active simultaneously for 8 cycles -> no flit lost or duplicated; assert reset with all buffers full -> next cycle all buffers empty and outputs at reset values.
